// File: rtl/rvfi_bus_fairness_monitor.sv
// Multi-channel valid/ready fairness and protocol monitor for formal wrappers.
// Tracks command stalls, response latency and outstanding reads per channel; drives `fair` from registers only.
module rvfi_bus_fairness_monitor #(
    parameter int NCH             = 2,
    parameter int MAX_CMD_WAIT    = 4,
    parameter int MAX_RSP_WAIT    = 4,
    parameter int MAX_OUTSTANDING = 1,
    parameter int STRICT_VALID    = 1,
    parameter int CW = $clog2(((MAX_CMD_WAIT > MAX_RSP_WAIT) ? MAX_CMD_WAIT : MAX_RSP_WAIT) + 1),
    parameter int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [NCH-1:0]    cmd_valid,
    input  logic [NCH-1:0]    cmd_ready,
    input  logic [NCH-1:0]    cmd_wr,
    input  logic [NCH-1:0]    rsp_valid,
    output logic              fair,
    output logic [NCH-1:0]    cmd_stall_err,
    output logic [NCH-1:0]    rsp_stall_err,
    output logic [NCH-1:0]    ovf_err,
    output logic [NCH-1:0]    unf_err,
    output logic [NCH-1:0]    drop_err,
    output logic [NCH*OW-1:0] outstanding
);

    localparam logic [CW-1:0] CMD_MAX = CW'(MAX_CMD_WAIT);
    localparam logic [CW-1:0] RSP_MAX = CW'(MAX_RSP_WAIT);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic          STRICT  = (STRICT_VALID != 0);

    logic [NCH-1:0] ch_ok;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] cmd_wait_reg, cmd_wait_next;
            logic [CW-1:0] rsp_wait_reg, rsp_wait_next;
            logic [OW-1:0] outs_reg, outs_next;
            logic          prev_valid_reg, prev_ready_reg;
            logic          cmd_stall_reg, rsp_stall_reg, ovf_reg, unf_reg, drop_reg;
            logic          acc_rd, out_full, out_empty, rsp_hit, inc;
            logic          ovf_hit, unf_hit, drop_hit;

            assign acc_rd    = cmd_valid[gi] & cmd_ready[gi] & ~cmd_wr[gi];
            assign out_full  = (outs_reg == OUT_MAX);
            assign out_empty = (outs_reg == '0);
            // A response only retires something already outstanding, never a same-cycle read.
            assign rsp_hit   = rsp_valid[gi] & ~out_empty;
            assign ovf_hit   = acc_rd & out_full & ~rsp_valid[gi];
            assign unf_hit   = rsp_valid[gi] & out_empty;
            assign inc       = acc_rd & ~ovf_hit;
            assign drop_hit  = STRICT & prev_valid_reg & ~prev_ready_reg & ~cmd_valid[gi];

            assign cmd_wait_next = (cmd_valid[gi] & ~cmd_ready[gi])
                                 ? ((cmd_wait_reg == CMD_MAX) ? CMD_MAX : cmd_wait_reg + CW'(1))
                                 : '0;
            assign rsp_wait_next = (out_empty | rsp_valid[gi])
                                 ? '0
                                 : ((rsp_wait_reg == RSP_MAX) ? RSP_MAX : rsp_wait_reg + CW'(1));
            assign outs_next     = outs_reg + OW'(inc) - OW'(rsp_hit);

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    cmd_wait_reg   <= '0;
                    rsp_wait_reg   <= '0;
                    outs_reg       <= '0;
                    prev_valid_reg <= 1'b0;
                    prev_ready_reg <= 1'b0;
                    cmd_stall_reg  <= 1'b0;
                    rsp_stall_reg  <= 1'b0;
                    ovf_reg        <= 1'b0;
                    unf_reg        <= 1'b0;
                    drop_reg       <= 1'b0;
                end else begin
                    cmd_wait_reg   <= cmd_wait_next;
                    rsp_wait_reg   <= rsp_wait_next;
                    outs_reg       <= outs_next;
                    prev_valid_reg <= cmd_valid[gi];
                    prev_ready_reg <= cmd_ready[gi];
                    cmd_stall_reg  <= cmd_stall_reg | (cmd_wait_next == CMD_MAX);
                    rsp_stall_reg  <= rsp_stall_reg | (rsp_wait_next == RSP_MAX);
                    ovf_reg        <= ovf_reg | ovf_hit;
                    unf_reg        <= unf_reg | unf_hit;
                    drop_reg       <= drop_reg | drop_hit;
                end
            end

            assign cmd_stall_err[gi]        = cmd_stall_reg;
            assign rsp_stall_err[gi]        = rsp_stall_reg;
            assign ovf_err[gi]              = ovf_reg;
            assign unf_err[gi]              = unf_reg;
            assign drop_err[gi]             = drop_reg;
            assign outstanding[gi*OW +: OW] = outs_reg;
            assign ch_ok[gi] = (cmd_wait_reg < CMD_MAX) & (rsp_wait_reg < RSP_MAX)
                             & ~(cmd_stall_reg | rsp_stall_reg | ovf_reg | unf_reg | drop_reg);
        end
    endgenerate

    assign fair = &ch_ok;

endmodule

// File: tb/tb_rvfi_bus_fairness_monitor.sv
// Scoreboard bench: two monitor configurations share random/directed stimulus;
// a behavioural model queues expected outputs, a negedge monitor pops and compares.
module tb_rvfi_bus_fairness_monitor;

    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] cmd_valid, cmd_ready, cmd_wr, rsp_valid;

    logic       fair0, fair1;
    logic [1:0] cse0, rse0, ovf0, unf0, drp0, outs0;
    logic [1:0] cse1, rse1, ovf1, unf1, drp1;
    logic [3:0] outs1;

    always #5 clock = ~clock;

    // dut0: strict, one outstanding read; dut1: non-strict, two outstanding reads
    rvfi_bus_fairness_monitor #(.NCH(2), .MAX_CMD_WAIT(4), .MAX_RSP_WAIT(4),
                                .MAX_OUTSTANDING(1), .STRICT_VALID(1)) dut0 (
        .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .rsp_valid(rsp_valid), .fair(fair0), .cmd_stall_err(cse0),
        .rsp_stall_err(rse0), .ovf_err(ovf0), .unf_err(unf0), .drop_err(drp0),
        .outstanding(outs0));

    rvfi_bus_fairness_monitor #(.NCH(2), .MAX_CMD_WAIT(4), .MAX_RSP_WAIT(4),
                                .MAX_OUTSTANDING(2), .STRICT_VALID(0)) dut1 (
        .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .rsp_valid(rsp_valid), .fair(fair1), .cmd_stall_err(cse1),
        .rsp_stall_err(rse1), .ovf_err(ovf1), .unf_err(unf1), .drop_err(drp1),
        .outstanding(outs1));

    typedef struct packed {
        logic       fair;
        logic [1:0] cse, rse, ovf, unf, drp;
        logic [7:0] outs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam int MAXC = 4;
    localparam int MAXR = 4;
    int  max_o[2]  = '{1, 2};
    bit  strict[2] = '{1'b1, 1'b0};

    // Reference state: cycles stalled, cycles the oldest read has waited, reads in flight
    int  m_cw[2][2], m_rw[2][2], m_os[2][2];
    bit  m_cse[2][2], m_rse[2][2], m_ovf[2][2], m_unf[2][2], m_drp[2][2];
    bit  m_pv[2][2], m_pr[2][2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (!resetn) begin
                    m_cw[k][c] = 0; m_rw[k][c] = 0; m_os[k][c] = 0;
                    m_cse[k][c] = 0; m_rse[k][c] = 0; m_ovf[k][c] = 0;
                    m_unf[k][c] = 0; m_drp[k][c] = 0; m_pv[k][c] = 0; m_pr[k][c] = 0;
                end else begin
                    bit v, r, w, rs, rd;
                    int old;
                    v = cmd_valid[c]; r = cmd_ready[c]; w = cmd_wr[c]; rs = rsp_valid[c];
                    rd  = v && r && !w;
                    old = m_os[k][c];
                    m_cw[k][c] = (v && !r) ? imin(m_cw[k][c] + 1, MAXC) : 0;
                    m_rw[k][c] = (old == 0 || rs) ? 0 : imin(m_rw[k][c] + 1, MAXR);
                    if (rs && old == 0) m_unf[k][c] = 1;
                    if (rd && old == max_o[k] && !rs) m_ovf[k][c] = 1;
                    m_os[k][c] = imin(old + (rd ? 1 : 0) - ((rs && old > 0) ? 1 : 0), max_o[k]);
                    if (m_cw[k][c] == MAXC) m_cse[k][c] = 1;
                    if (m_rw[k][c] == MAXR) m_rse[k][c] = 1;
                    if (strict[k] && m_pv[k][c] && !m_pr[k][c] && !v) m_drp[k][c] = 1;
                    m_pv[k][c] = v; m_pr[k][c] = r;
                end
            end
            e = '0;
            e.fair = 1'b1;
            for (int c = 0; c < 2; c++) begin
                if (m_cw[k][c] >= MAXC || m_rw[k][c] >= MAXR || m_cse[k][c] || m_rse[k][c] ||
                    m_ovf[k][c] || m_unf[k][c] || m_drp[k][c]) e.fair = 1'b0;
                e.cse[c] = m_cse[k][c]; e.rse[c] = m_rse[k][c]; e.ovf[c] = m_ovf[k][c];
                e.unf[c] = m_unf[k][c]; e.drp[c] = m_drp[k][c];
                e.outs[c*4 +: 4] = 4'(m_os[k][c]);
            end
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("fair0", fair0, e.fair);
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("cmd_stall0_ch%0d", c), cse0[c], e.cse[c]);
                chk($sformatf("rsp_stall0_ch%0d", c), rse0[c], e.rse[c]);
                chk($sformatf("ovf0_ch%0d", c), ovf0[c], e.ovf[c]);
                chk($sformatf("unf0_ch%0d", c), unf0[c], e.unf[c]);
                chk($sformatf("drop0_ch%0d", c), drp0[c], e.drp[c]);
                chk($sformatf("outs0_ch%0d", c), outs0[c], e.outs[c*4 +: 4]);
            end
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("fair1", fair1, e.fair);
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("cmd_stall1_ch%0d", c), cse1[c], e.cse[c]);
                chk($sformatf("rsp_stall1_ch%0d", c), rse1[c], e.rse[c]);
                chk($sformatf("ovf1_ch%0d", c), ovf1[c], e.ovf[c]);
                chk($sformatf("unf1_ch%0d", c), unf1[c], e.unf[c]);
                chk($sformatf("drop1_ch%0d", c), drp1[c], e.drp[c]);
                chk($sformatf("outs1_ch%0d", c), outs1[c*2 +: 2], e.outs[c*4 +: 4]);
            end
        end
        $display("cyc %0d rn=%0b v=%b r=%b w=%b rs=%b | fair0=%0b outs0=%h err0=%b%b%b%b%b | fair1=%0b outs1=%h",
                 cyc, resetn, cmd_valid, cmd_ready, cmd_wr, rsp_valid, fair0, outs0,
                 cse0, rse0, ovf0, unf0, drp0, fair1, outs1);
        cyc++;
    end

    task automatic step(input bit rn, input logic [1:0] v, input logic [1:0] r,
                        input logic [1:0] w, input logic [1:0] rs);
        resetn = rn; cmd_valid = v; cmd_ready = r; cmd_wr = w; rsp_valid = rs;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic rst();
        step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        logic [1:0] v, r, w, rs;
        bit rn;
        rst(); rst();
        // ch0 command stall of 4 cycles, then accepted as a write
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
        idle(2); rst();
        // ch1 read, response three cycles later
        step(1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
        idle(2);
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b10);
        idle(2);
        // ch0 write, no response expected
        step(1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
        idle(10);
        // back-to-back reads on ch0: overflow for dut0, two in flight for dut1
        step(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
        rst();
        // second read with a same-cycle response: no overflow
        step(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b01, 2'b00, 2'b01);
        idle(2); rst();
        // response with nothing outstanding, then a withdrawn command on ch1
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b10);
        step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        idle(1); rst();
        // reset mid-stall
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        rst();
        idle(2);
        // randomized traffic with occasional resets
        v = 2'b00; r = 2'b00;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 39) != 0);
            for (int c = 0; c < 2; c++) begin
                v[c]  = (v[c] && !r[c]) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
                r[c]  = ($urandom_range(0, 2) == 0);
                w[c]  = ($urandom_range(0, 1) != 0);
                rs[c] = ($urandom_range(0, 3) == 0);
            end
            step(rn, v, r, w, rs);
        end
        idle(1);
        @(negedge clock); #1;
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
